// File: rtl/ram_burst.sv
// Single-write / burst-read staging memory. Each read gathers BURST_LEN
// consecutive words (address wraps mod DEPTH), packed MSB-first, two edges later.
module ram_burst #(
    parameter int WIDTH      = 8,
    parameter int BURST_LEN  = 4,
    parameter int DEPTH      = 1024,
    parameter int DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic [DEPTH_BITS-1:0]      write_address,
    input  logic [WIDTH-1:0]           write_data_in,
    input  logic                       read_en,
    input  logic [DEPTH_BITS-1:0]      read_address,
    output logic [BURST_LEN*WIDTH-1:0] read_data_out,
    output logic                       read_valid
);
    localparam int STAGES = 2;

    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Lane BURST_LEN-1 is the first word so the packed vector comes out MSB-first.
    logic [BURST_LEN-1:0][WIDTH-1:0] gather;
    logic [BURST_LEN-1:0][WIDTH-1:0] s1_data;
    logic [BURST_LEN-1:0][WIDTH-1:0] s2_data;
    logic [STAGES:1]                 vld_pipe;

    for (genvar k = 0; k < BURST_LEN; k++) begin : g_lane
        logic [DEPTH_BITS-1:0] addr;
        assign addr                    = read_address + DEPTH_BITS'(k);
        assign gather[BURST_LEN-1-k]   = mem[addr];
    end

    // Gather reads mem combinationally before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (write_en) mem[write_address] <= write_data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s2_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], read_en};
            if (read_en)     s1_data <= gather;
            if (vld_pipe[1]) s2_data <= s1_data;
        end
    end

    assign read_data_out = s2_data;
    assign read_valid    = vld_pipe[STAGES];
endmodule

// File: tb/tb_ram_burst.sv
// Directed + randomized bench for ram_burst against an array/arithmetic model.
module tb_ram_burst;
    localparam int W  = 8;
    localparam int BL = 4;
    localparam int D  = 1024;
    localparam int AB = 10;

    logic              clk = 0;
    logic              rst = 1;
    logic              write_en = 0;
    logic [AB-1:0]     write_address = '0;
    logic [W-1:0]      write_data_in = '0;
    logic              read_en = 0;
    logic [AB-1:0]     read_address = '0;
    logic [BL*W-1:0]   read_data_out;
    logic              read_valid;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    ref_mem [D];
    logic            m1_v, m_v;
    logic [BL*W-1:0] m1_d, m_d;

    ram_burst #(.WIDTH(W), .BURST_LEN(BL), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .write_address(write_address), .write_data_in(write_data_in),
        .read_en(read_en), .read_address(read_address),
        .read_data_out(read_data_out), .read_valid(read_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [BL*W-1:0] burst(input int a);
        logic [BL*W-1:0] r = '0;
        for (int k = 0; k < BL; k++) r = (r << W) | (BL*W)'(ref_mem[(a + k) % D]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [BL*W-1:0] obs, input logic [BL*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model by one edge, check both outputs.
    task automatic cycle(input logic we, input int wa, input logic [W-1:0] wd,
                         input logic re, input int ra);
        write_en = we; write_address = AB'(wa); write_data_in = wd;
        read_en = re;  read_address = AB'(ra);
        @(posedge clk);
        m_v = m1_v;
        if (m1_v) m_d = m1_d;
        m1_v = re;
        if (re) m1_d = burst(ra);
        if (we) ref_mem[wa] = wd;
        #1;
        write_en = 0; read_en = 0;
        chk("read_valid", {31'b0, read_valid}, {31'b0, m_v});
        chk("read_data_out", read_data_out, m_d);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        m1_v = 0; m_v = 0; m1_d = '0; m_d = '0;

        #12;
        chk("reset_data", read_data_out, '0);
        chk("reset_valid", {31'b0, read_valid}, 32'd0);
        @(negedge clk);
        rst = 0;

        // Sequential fill, then sweep every 4th address
        for (int i = 0; i < D; i++) cycle(1, i, W'(i % 256), 0, 0);
        for (int a = 0; a < D; a += 4) cycle(0, 0, 0, 1, a);
        idle(); idle();

        cycle(0, 0, 0, 1, 8);     idle(); chk("fill_8", read_data_out, 32'h08090A0B);
        cycle(0, 0, 0, 1, 252);   idle(); chk("fill_252", read_data_out, 32'hFCFDFEFF);
        cycle(0, 0, 0, 1, 1022);  idle(); chk("wrap_1022", read_data_out, 32'hFEFF0001);

        // Back-to-back bursts, one result per edge
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 4);  chk("pipe0", read_data_out, 32'h00010203);
        cycle(0, 0, 0, 1, 8);  chk("pipe1", read_data_out, 32'h04050607);
        idle();                chk("pipe2", read_data_out, 32'h08090A0B);
        idle();                chk("pipe_hold", read_data_out, 32'h08090A0B);
        chk("pipe_hold_valid", {31'b0, read_valid}, 32'd0);

        // Pattern / packing
        cycle(1, 100, 8'hAA, 0, 0);
        cycle(1, 101, 8'hBB, 0, 0);
        cycle(1, 102, 8'hCC, 0, 0);
        cycle(1, 103, 8'hDD, 0, 0);
        cycle(0, 0, 0, 1, 100); idle();
        chk("pattern", read_data_out, 32'hAABBCCDD);
        chk("byte0", {24'b0, read_data_out[7:0]}, 32'hDD);

        // Read-during-write: read-first
        cycle(1, 101, 8'h55, 1, 100); idle();
        chk("rdw_old", read_data_out, 32'hAABBCCDD);
        cycle(0, 0, 0, 1, 100); idle();
        chk("rdw_new", read_data_out, 32'hAA55CCDD);

        // Reset between edge N and N+1 of a burst
        cycle(0, 0, 0, 1, 100);
        #2 rst = 1;
        #1;
        chk("rst_async_data", read_data_out, '0);
        chk("rst_async_valid", {31'b0, read_valid}, 32'd0);
        m1_v = 0; m_v = 0; m1_d = '0; m_d = '0;
        @(posedge clk); #1;
        chk("rst_no_pulse", {31'b0, read_valid}, 32'd0);
        chk("rst_hold_data", read_data_out, '0);
        @(negedge clk);
        rst = 0;
        cycle(0, 0, 0, 1, 100);
        chk("post_rst_latency", {31'b0, read_valid}, 32'd0);
        idle();
        chk("post_rst_valid", {31'b0, read_valid}, 32'd1);
        chk("post_rst_retained", read_data_out, 32'hAA55CCDD);

        // Random mix focused on a small window plus the wrap region
        for (int n = 0; n < 400; n++) begin
            int wa, ra;
            wa = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(D - 8, D - 1);
            ra = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(D - 8, D - 1);
            cycle(1'($urandom_range(0, 1)), wa, W'($urandom), 1'($urandom_range(0, 2) != 0), ra);
        end
        idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
